// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares the single core ALU between NREQ requesters. One operation is in
//   flight at a time: IDLE (arbitrate/accept) -> ISSUE (alu_en pulse) ->
//   WAIT (ALU_LAT edges) -> RESP (one-cycle resp_valid to the winner).
//
//   Optional build macro:
//     ALU_ARB_PRIO_EN  requester 0 is fixed highest priority; round-robin
//                      runs over requesters 1..NREQ-1 only. When undefined,
//                      arbitration is pure round-robin over all requesters.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NREQ    = 4,   // number of requesters (2..8)
    parameter int ALU_LAT = 1    // edges from alu_en sample to alu_result valid (>=1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_result,
    output logic                 resp_zero,
    output logic                 busy,
    output logic                 alu_en,
    output logic [3:0]           alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_result
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic [CW-1:0]   wait_cnt;

    logic [IDW-1:0]  grant;
    logic            grant_found;
    logic [IDW-1:0]  rr_next;
    logic [IDW-1:0]  scan_base;
    logic [IDW:0]    scan_sum;
    logic [IDW-1:0]  scan_idx;

    logic [3:0]      sel_op;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;

    // Pick the winner: first valid requester at or after the round-robin pointer.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        grant       = '0;
        grant_found = 1'b0;
        scan_base   = rr_ptr;
        scan_sum    = '0;
        scan_idx    = '0;
`ifdef ALU_ARB_PRIO_EN
        // Requester 0 preempts; the rotating scan covers indices 1..NREQ-1.
        scan_base = (rr_ptr == '0) ? IDW'(1) : rr_ptr;
        if (req_valid[0]) begin
            grant       = '0;
            grant_found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                scan_sum = {1'b0, scan_base} + (IDW+1)'(k);
                if (scan_sum >= (IDW+1)'(NREQ))
                    scan_sum = scan_sum - (IDW+1)'(NREQ - 1);
                scan_idx = scan_sum[IDW-1:0];
                if (!grant_found && req_valid[scan_idx]) begin
                    grant       = scan_idx;
                    grant_found = 1'b1;
                end
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, scan_base} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NREQ))
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            scan_idx = scan_sum[IDW-1:0];
            if (!grant_found && req_valid[scan_idx]) begin
                grant       = scan_idx;
                grant_found = 1'b1;
            end
        end
`endif
    end

    // Pointer value to load on accept: one past the winner, wrapping.
    always_comb begin
        rr_next = '0;
`ifdef ALU_ARB_PRIO_EN
        // A priority grant to requester 0 leaves the rotation untouched.
        if (grant == '0)
            rr_next = rr_ptr;
        else if (grant == IDW'(NREQ - 1))
            rr_next = IDW'(1);
        else
            rr_next = grant + IDW'(1);
`else
        if (grant == IDW'(NREQ - 1))
            rr_next = '0;
        else
            rr_next = grant + IDW'(1);
`endif
    end

    // Route the winner's opcode and operands to the capture registers.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    // Accept strobe: only in IDLE, one-hot on the winner, silent while in reset.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found && !reset)
            req_ready = NREQ'(1) << grant;
    end

    assign busy = (state != S_IDLE);

    // Operation sequencer and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            wait_cnt    <= '0;
            alu_en      <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values; the pulse defaults below are overridden later
            // in the same block where a pulse is due.
            alu_en     <= 1'b0;
            resp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        alu_op   <= sel_op;
                        alu_a    <= sel_a;
                        alu_b    <= sel_b;
                        grant_id <= grant;
                        rr_ptr   <= rr_next;
                        alu_en   <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= CW'(ALU_LAT);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // The ALU zero flag is ignored; zero is derived from the result.
                    if (wait_cnt == CW'(1)) begin
                        resp_result <= alu_result;
                        resp_zero   <= (alu_result == 32'd0);
                        resp_valid  <= NREQ'(1) << grant_id;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Two instances: ALU_LAT=1 (main) and
//   ALU_LAT=3 (latency timing). Each has a behavioural ALU that returns a
//   poison value in every cycle the result is not due.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ALU_LAT = 1 instance signals
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    resp_valid;
    logic [31:0]        resp_result;
    logic               resp_zero;
    logic               busy;
    logic               alu_en;
    logic [3:0]         alu_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [31:0]        alu_result;

    // ALU_LAT = 3 instance signals
    logic [NREQ-1:0]    l3_req_valid;
    logic [NREQ-1:0]    l3_req_ready;
    logic [4*NREQ-1:0]  l3_req_op;
    logic [32*NREQ-1:0] l3_req_a;
    logic [32*NREQ-1:0] l3_req_b;
    logic [NREQ-1:0]    l3_resp_valid;
    logic [31:0]        l3_resp_result;
    logic               l3_resp_zero;
    logic               l3_busy;
    logic               l3_alu_en;
    logic [3:0]         l3_alu_op;
    logic [31:0]        l3_alu_a;
    logic [31:0]        l3_alu_b;
    logic [31:0]        l3_alu_result;
    logic [31:0]        l3_p0, l3_p1, l3_p2;

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_zero(resp_zero),
        .busy(busy), .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result)
    );

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(l3_req_valid), .req_ready(l3_req_ready),
        .req_op(l3_req_op), .req_a(l3_req_a), .req_b(l3_req_b),
        .resp_valid(l3_resp_valid), .resp_result(l3_resp_result), .resp_zero(l3_resp_zero),
        .busy(l3_busy), .alu_en(l3_alu_en), .alu_op(l3_alu_op), .alu_a(l3_alu_a), .alu_b(l3_alu_b),
        .alu_result(l3_alu_result)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            default: return a ^ ~b;
        endcase
    endfunction

    // One-edge ALU: result valid in the cycle after alu_en is sampled.
    always @(posedge clk)
        alu_result <= alu_en ? alu_model(alu_op, alu_a, alu_b) : 32'hDEAD_BEEF;

    // Three-edge ALU pipeline.
    always @(posedge clk) begin
        l3_p0 <= l3_alu_en ? alu_model(l3_alu_op, l3_alu_a, l3_alu_b) : 32'hDEAD_BEEF;
        l3_p1 <= l3_p0;
        l3_p2 <= l3_p1;
    end
    assign l3_alu_result = l3_p2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t        vecs[8];
    int          exp_grant[8];
    logic [31:0] exp_res[4];

    task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_op[4*idx +: 4]  = op;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_valid    = '0;
        l3_req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Single isolated transaction on the ALU_LAT=1 instance, accept in cycle 0.
    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        oh = 4'b0001 << v.idx;
        set_req(v.idx, v.op, v.a, v.b);
        req_valid = oh;
        #1;
        check("vec c0 req_ready", 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = '0;
        check("vec c1 alu_en", 32'(alu_en), 32'd1);
        check("vec c1 alu_op", 32'(alu_op), 32'(v.op));
        check("vec c1 alu_a", alu_a, v.a);
        check("vec c1 alu_b", alu_b, v.b);
        check("vec c1 busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("vec c2 alu_en", 32'(alu_en), 32'd0);
        check("vec c2 resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("vec c3 resp_valid", 32'(resp_valid), 32'(oh));
        check("vec c3 resp_result", resp_result, v.res);
        check("vec c3 resp_zero", 32'(resp_zero), 32'(v.zero));
        @(negedge clk);
        check("vec c4 resp_valid", 32'(resp_valid), 32'd0);
        check("vec c4 result held", resp_result, v.res);
        check("vec c4 zero held", 32'(resp_zero), 32'(v.zero));
        check("vec c4 busy", 32'(busy), 32'd0);
    endtask

    // Back-to-back grants with requests held; one accept every 4 cycles.
    task automatic stream(input int n);
        for (int t = 0; t < n; t++) begin
            int g;
            g = exp_grant[t];
            #1;
            check("stream accept req_ready", 32'(req_ready), 32'(4'b0001 << g));
            repeat (3) @(negedge clk);
            check("stream resp_valid", 32'(resp_valid), 32'(4'b0001 << g));
            check("stream resp_result", resp_result, exp_res[g]);
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    initial begin
        bit saw_resp;

        vecs[0] = '{0, 4'h0, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1, 4'h1, 32'd9,          32'd9,          32'd0,          1'b1};
        vecs[2] = '{2, 4'h2, 32'h0000_F0F0,  32'h0000_0F0F,  32'd0,          1'b1};
        vecs[3] = '{3, 4'h3, 32'hF000_0000,  32'd1,          32'hF000_0001,  1'b0};
        vecs[4] = '{0, 4'h4, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[5] = '{2, 4'hF, 32'd3,          32'd5,          32'hFFFF_FFF9,  1'b0};
        vecs[6] = '{1, 4'h0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[7] = '{3, 4'h1, 32'd10,         32'd3,          32'd7,          1'b0};

        reset        = 1'b1;
        req_valid    = '0;
        req_op       = '0;
        req_a        = '0;
        req_b        = '0;
        l3_req_valid = '0;
        l3_req_op    = '0;
        l3_req_a     = '0;
        l3_req_b     = '0;

        // Reset state
        @(negedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_result", resp_result, 32'd0);
        check("reset resp_zero", 32'(resp_zero), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset alu_en", 32'(alu_en), 32'd0);
        check("reset alu_op", 32'(alu_op), 32'd0);
        check("reset alu_a", alu_a, 32'd0);
        check("reset alu_b", alu_b, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Isolated transactions from the vector table
        for (int i = 0; i < 8; i++)
            run_vec(vecs[i]);

        // req0 and req2 held valid from reset
        do_reset();
        set_req(0, 4'h0, 32'd1000, 32'd1);
        set_req(2, 4'h1, 32'd50, 32'd8);
        exp_res[0] = 32'd1001;
        exp_res[1] = 32'd0;
        exp_res[2] = 32'd42;
        exp_res[3] = 32'd0;
`ifdef ALU_ARB_PRIO_EN
        exp_grant[0] = 0; exp_grant[1] = 0; exp_grant[2] = 0; exp_grant[3] = 0;
`else
        exp_grant[0] = 0; exp_grant[1] = 2; exp_grant[2] = 0; exp_grant[3] = 2;
`endif
        req_valid = 4'b0101;
        stream(4);

        // All four requesters held valid from reset
        do_reset();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 4'h0, 32'(100 * (i + 1)), 32'(i + 1));
        exp_res[0] = 32'd101;
        exp_res[1] = 32'd202;
        exp_res[2] = 32'd303;
        exp_res[3] = 32'd404;
        for (int t = 0; t < 8; t++) begin
`ifdef ALU_ARB_PRIO_EN
            exp_grant[t] = 0;
`else
            exp_grant[t] = t % 4;
`endif
        end
        req_valid = 4'b1111;
        stream(8);

        // Reset during WAIT discards the in-flight op
        @(negedge clk);
        set_req(2, 4'h3, 32'd7, 32'd8);
        req_valid = 4'b0100;
        #1;
        check("rst-wait accept req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("rst-wait in WAIT busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst-wait busy", 32'(busy), 32'd0);
        check("rst-wait resp_valid", 32'(resp_valid), 32'd0);
        check("rst-wait resp_result", resp_result, 32'd0);
        check("rst-wait alu_en", 32'(alu_en), 32'd0);
        check("rst-wait alu_op", 32'(alu_op), 32'd0);
        check("rst-wait alu_a", alu_a, 32'd0);
        check("rst-wait alu_b", alu_b, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_resp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid != '0) saw_resp = 1'b1;
        end
        check("rst-wait no stray resp_valid", 32'(saw_resp), 32'd0);
        // Pointer restarts at 0: req2 beats req3, then req3 is next.
        set_req(3, 4'h0, 32'd30, 32'd3);
        req_valid = 4'b1100;
        #1;
        check("post-rst grant req2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        check("post-rst resp req2", 32'(resp_valid), 32'b0100);
        check("post-rst result req2", resp_result, 32'd15);
        @(negedge clk);
        #1;
        check("post-rst grant req3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("post-rst resp req3", 32'(resp_valid), 32'b1000);
        check("post-rst result req3", resp_result, 32'd33);
        @(negedge clk);

        // ALU_LAT=3 timing: alu_en c1, resp c5, next accept c6
        l3_req_op[4*1 +: 4]   = 4'h0;
        l3_req_a[32*1 +: 32]  = 32'd20;
        l3_req_b[32*1 +: 32]  = 32'd22;
        l3_req_valid = 4'b0010;
        #1;
        check("lat3 c0 req_ready", 32'(l3_req_ready), 32'b0010);
        @(negedge clk);
        check("lat3 c1 alu_en", 32'(l3_alu_en), 32'd1);
        check("lat3 c1 req_ready", 32'(l3_req_ready), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check("lat3 wait resp_valid", 32'(l3_resp_valid), 32'd0);
            check("lat3 wait alu_en", 32'(l3_alu_en), 32'd0);
            check("lat3 wait req_ready", 32'(l3_req_ready), 32'd0);
        end
        @(negedge clk);
        check("lat3 c5 resp_valid", 32'(l3_resp_valid), 32'b0010);
        check("lat3 c5 resp_result", l3_resp_result, 32'd42);
        check("lat3 c5 resp_zero", 32'(l3_resp_zero), 32'd0);
        check("lat3 c5 no accept in RESP", 32'(l3_req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("lat3 c6 re-accept", 32'(l3_req_ready), 32'b0010);
        l3_req_valid = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
